// File: rtl/sine_meter_pkg.sv
// Shared types and constants for the sine_gen cycle meter.
package sine_meter_pkg;

  localparam int unsigned SAMPLE_W = 20;
  localparam int unsigned PW_DEF   = 16;
  localparam int unsigned HYST_DEF = 16;
  localparam int unsigned DROP_W   = 8;

  typedef enum logic {
    ACQUIRE = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;

  // period field is sized for the widest supported counter; narrower PW zero-extends
  typedef struct packed {
    logic [PW_DEF-1:0]          period;
    logic signed [SAMPLE_W-1:0] peak;
    logic signed [SAMPLE_W-1:0] trough;
    logic                       ovf;
  } meter_result_t;

endpackage

// File: rtl/sine_extrema_tracker.sv
// Running signed max/min of accepted samples; restart reloads both with the current sample.
module sine_extrema_tracker
  import sine_meter_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_en,
  input  logic                       i_restart,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic signed [SAMPLE_W-1:0] o_max,
  output logic signed [SAMPLE_W-1:0] o_min
);

  logic signed [SAMPLE_W-1:0] r_max;
  logic signed [SAMPLE_W-1:0] r_min;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_max <= '0;
      r_min <= '0;
    end else if (i_restart) begin
      r_max <= i_sample;
      r_min <= i_sample;
    end else if (i_en) begin
      if (i_sample > r_max) r_max <= i_sample;
      if (i_sample < r_min) r_min <= i_sample;
    end
  end

  assign o_max = r_max;
  assign o_min = r_min;

endmodule

// File: rtl/sine_cycle_meter.sv
// Measures period, peak and trough of each sine cycle (rising crossings gated by a
// negative-hysteresis arm) and presents results on a one-deep valid/ready register.
module sine_cycle_meter
  import sine_meter_pkg::*;
#(
  parameter int unsigned PW   = PW_DEF,
  parameter int unsigned HYST = HYST_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PW-1:0]       out_period,
  output logic [SAMPLE_W-1:0] out_peak,
  output logic [SAMPLE_W-1:0] out_trough,
  output logic                out_ovf,
  output logic [DROP_W-1:0]   drop_count
);

  localparam logic signed [SAMPLE_W-1:0] NEG_HYST = SAMPLE_W'(-$signed(HYST));
  localparam logic [PW-1:0]              CNT_MAX  = {PW{1'b1}};

  meter_state_e               r_state, w_state_nxt;
  logic                       r_armed, w_armed_nxt;
  logic [PW-1:0]              r_cnt;
  logic                       r_ovf;
  meter_result_t              r_res;
  logic                       r_out_valid;
  logic [DROP_W-1:0]          r_drop;

  logic signed [SAMPLE_W-1:0] w_sample;
  logic signed [SAMPLE_W-1:0] w_peak;
  logic signed [SAMPLE_W-1:0] w_trough;
  logic                       w_arm_hit;
  logic                       w_cross;
  logic                       w_emit;
  logic                       w_load;
  logic                       w_trk_en;

  assign w_sample  = $signed(in_sample);
  assign w_arm_hit = in_valid && (w_sample <= NEG_HYST);
  assign w_cross   = in_valid && r_armed && !in_sample[SAMPLE_W-1];
  assign w_emit    = w_cross && (r_state == MEASURE);
  assign w_load    = w_emit && (!r_out_valid || out_ready);
  assign w_trk_en  = in_valid && (r_state == MEASURE) && !w_cross;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACQUIRE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // a crossing both starts measurement and disarms until the next deep negative sample
  always_comb begin
    w_state_nxt = r_state;
    w_armed_nxt = r_armed;
    if (w_cross) begin
      w_state_nxt = MEASURE;
      w_armed_nxt = 1'b0;
    end else if (w_arm_hit) begin
      w_armed_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_cross) begin
      r_cnt <= PW'(1);
      r_ovf <= 1'b0;
    end else if (w_trk_en) begin
      if (r_cnt == CNT_MAX) r_ovf <= 1'b1;
      else                  r_cnt <= r_cnt + PW'(1);
    end
  end

  sine_extrema_tracker u_trk (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_trk_en),
    .i_restart (w_cross),
    .i_sample  (w_sample),
    .o_max     (w_peak),
    .o_min     (w_trough)
  );

  // one-deep result register; a full register with no handoff drops the new result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_drop      <= '0;
    end else begin
      if (w_load) begin
        r_res.period <= PW_DEF'(r_cnt);
        r_res.peak   <= w_peak;
        r_res.trough <= w_trough;
        r_res.ovf    <= r_ovf;
        r_out_valid  <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid  <= 1'b0;
      end
      if (w_emit && !w_load && (r_drop != {DROP_W{1'b1}})) r_drop <= r_drop + DROP_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_period = r_res.period[PW-1:0];
  assign out_peak   = r_res.peak;
  assign out_trough = r_res.trough;
  assign out_ovf    = r_res.ovf;
  assign drop_count = r_drop;

endmodule

// File: doc/sine_cycle_meter.md
# sine_cycle_meter

Downstream monitor for the `sine_gen` oscillator output in the ECG signal chain. It consumes the 20-bit signed sine sample on every enabled tick (the same `en` strobe that advances `sine_gen`). For each full cycle it measures the period in samples, the positive peak and the negative trough. Each cycle's result is presented on a one-deep valid/ready output register for calibration and amplitude-control logic.

## Interface
- `PW`, 16: period counter / output width in bits.
- `HYST`, 16: arming threshold magnitude; a sample must reach ≤ −HYST before a rising crossing is accepted.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample strobe; tie to the `sine_gen` `en`.
- `in_sample`  in  20  signed two's-complement sine sample; sampled only when `in_valid`=1.
- `out_valid`  out  1  result register holds an unconsumed cycle measurement.
- `out_ready`  in  1  consumer accepts the result when `out_valid`&`out_ready`.
- `out_period`  out  PW  samples in the completed cycle.
- `out_peak`  out  20  signed maximum sample of the completed cycle.
- `out_trough`  out  20  signed minimum sample of the completed cycle.
- `out_ovf`  out  1  period counter saturated during this cycle.
- `drop_count`  out  8  saturating count of results lost because the output register was full.

## Operation
- There are two states, ACQUIRE and MEASURE, and a separate `armed` flag.
- Reset: state ACQUIRE, `armed`=0, counter=0, trackers cleared. All outputs 0; `out_valid`=0, `drop_count`=0.
- `armed` sets on any accepted sample ≤ −HYST (signed compare). It clears on a crossing.
- A crossing is an accepted sample ≥ 0 while `armed`=1. The crossing sample itself belongs to the new cycle.
- ACQUIRE: samples only update `armed`, with no measurement. On the first crossing:
  - go to MEASURE;
  - set counter=1, peak=trough=current sample, ovf=0.
  - No result is emitted.
- MEASURE, non-crossing sample:
  - counter+1, saturating at 2^PW−1; ovf sets on saturation;
  - peak=max(peak,sample), trough=min(trough,sample), both signed.
- MEASURE, crossing sample:
  - the finished cycle's {counter, peak, trough, ovf} is offered to the output;
  - the trackers restart with counter=1 and peak=trough=sample.
- Output register load rules:
  - Loads if `out_valid`=0, or if `out_valid`&`out_ready` in the same cycle (handoff plus reload; not a drop).
  - Otherwise the new result is discarded, the held result is unchanged, and `drop_count`+1 (saturates at 255).
- `out_valid` clears on `out_valid`&`out_ready` when no new result loads that cycle.
- Output fields are stable while `out_valid`=1 and `out_ready`=0.
- `in_valid`=0 cycles change nothing; the period counts samples, not clocks.

## Timing
- Crossing sample accepted in cycle N → `out_valid`=1 with its result from cycle N+1.
- Back-to-back crossings on consecutive samples are legal; each emits a result, and period=1 is possible.
- `reset` asserted mid-cycle: on the next edge every register returns to its reset value. The pending result is lost and `drop_count` is cleared. The block re-enters ACQUIRE and requires re-arming.
- `reset` has priority over every other input in the same cycle.

## Structure
- Package `sine_meter_pkg` contains:
  - the state enum (ACQUIRE, MEASURE);
  - the sample width constant (20);
  - default `PW`/`HYST` localparams;
  - a measurement result struct {period, peak, trough, ovf}.
- Sub-module `sine_extrema_tracker`: running signed max/min with a restart input. It is instantiated once in the top.
- Top holds the FSM, arming logic, counter and output register.

## Test plan
- Reset behaviour: reset held 3 cycles with samples toggling → all outputs 0. Then 10 samples of +100 → no result and state stays ACQUIRE (never armed).
- Synthetic square wave: repeat {−100×5, +100×5}, continuous `in_valid` → after the first crossing, each result is period=10, peak=100, trough=−100, ovf=0. Each `out_valid` appears 1 cycle after its crossing sample.
- Hysteresis: repeat {−10×5, +10×5} with HYST=16 → never arms, no results.
- Backpressure: square wave as above with `out_ready`=0 for 25 samples → the first result is held unchanged and `drop_count`=2. When ready returns, the held result is accepted and the next crossing loads normally.
- Live oscillator: drive from `sine_gen` (cos init 0x2666, gated `en` every 3rd clock) → period 1607–1609 samples with peak within ±0x40 of 0x2666 and trough within ±0x40 of −0x2666. Clock count between results equals 3×period.
- Overflow and mid-cycle reset:
  - PW=4 with crossings 20 samples apart → period=15, ovf=1.
  - Reset asserted mid-cycle → outputs 0, and the next result requires a fresh arm plus crossing.
